// File: rtl/counter_sched_if.sv
// rtl/counter_sched_if.sv - request bus between two requesters and the counter scheduler
interface counter_sched_if #(
    parameter int WIDTH = 4
) ();
    logic [1:0]         req_valid;
    logic [1:0]         req_dir;
    logic [2*WIDTH-1:0] req_target;
    logic [1:0]         req_ready;

    modport master (
        output req_valid,
        output req_dir,
        output req_target,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dir,
        input  req_target,
        output req_ready
    );
endinterface

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin scheduler sharing one up/down counter between two requesters
// Optional job abort input enabled by defining COUNTER_SCHED_ABORT_EN.
module counter_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    counter_sched_if.slave   req_if,
`ifdef COUNTER_SCHED_ABORT_EN
    input  logic             abort,
`endif
    output logic             cnt_reset,
    output logic             cnt_up_down,
    output logic             cnt_enable,
    input  logic [WIDTH-1:0] cnt_count,
    output logic             busy,
    output logic             done,
    output logic             done_id
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             rr_q, rr_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             id_q, id_d;
    logic             grant_id;
    logic             abort_hit;

    always_comb begin
        state_d            = state_q;
        rr_d               = rr_q;
        dir_d              = dir_q;
        target_d           = target_q;
        id_d               = id_q;
        grant_id           = 1'b0;
        abort_hit          = 1'b0;
        req_if.req_ready   = 2'b00;
        cnt_reset          = 1'b0;
        cnt_up_down        = 1'b0;
        cnt_enable         = 1'b0;
        done               = 1'b0;
        done_id            = 1'b0;
        busy               = (state_q != ST_IDLE);
`ifdef COUNTER_SCHED_ABORT_EN
        abort_hit          = abort;
`endif

        case (state_q)
            ST_IDLE: begin
                // reset_n gate keeps req_ready low while reset is held with requests pending
                if (reset_n && (req_if.req_valid != 2'b00)) begin
                    grant_id = (req_if.req_valid == 2'b11) ? ~rr_q : req_if.req_valid[1];
                    req_if.req_ready = grant_id ? 2'b10 : 2'b01;
                    rr_d     = grant_id;
                    id_d     = grant_id;
                    dir_d    = req_if.req_dir[grant_id];
                    target_d = grant_id ? req_if.req_target[2*WIDTH-1:WIDTH]
                                        : req_if.req_target[WIDTH-1:0];
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_reset   = 1'b1;
                cnt_up_down = dir_q;
                state_d     = abort_hit ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                cnt_up_down = dir_q;
                if (abort_hit) begin
                    state_d = ST_IDLE;
                end else if (cnt_count == target_q) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            default: begin
                done    = 1'b1;
                done_id = id_q;
                state_d = ST_IDLE;
            end
        endcase
    end

    // rr_q resets to requester 1 so requester 0 wins the first tie
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rr_q     <= 1'b1;
            dir_q    <= 1'b0;
            target_q <= '0;
            id_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            dir_q    <= dir_d;
            target_q <= target_d;
            id_q     <= id_d;
        end
    end

endmodule

// File: tb/tb_counter_sched.sv
// tb/tb_counter_sched.sv - self-checking bench for counter_sched with a shared counter and job-level reference model
module tb_counter_sched;
    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         cnt_reset, cnt_up_down, cnt_enable;
    logic         busy, done, done_id;
    logic [W-1:0] cnt_count = '0;
`ifdef COUNTER_SCHED_ABORT_EN
    logic         abort = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int last_grant = 1;

    counter_sched_if #(.WIDTH(W)) rif ();

    counter_sched #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_if      (rif.slave),
`ifdef COUNTER_SCHED_ABORT_EN
        .abort       (abort),
`endif
        .cnt_reset   (cnt_reset),
        .cnt_up_down (cnt_up_down),
        .cnt_enable  (cnt_enable),
        .cnt_count   (cnt_count),
        .busy        (busy),
        .done        (done),
        .done_id     (done_id)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (cnt_reset)       cnt_count <= cnt_up_down ? '0 : '1;
        else if (cnt_enable) cnt_count <= cnt_up_down ? cnt_count + 1'b1 : cnt_count - 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int steps(input logic dir, input logic [W-1:0] tgt);
        return dir ? int'(tgt) : MAXV - int'(tgt);
    endfunction

    // Called at a negedge while the scheduler is idle; returns at the following idle negedge.
    task automatic run_job(input logic [1:0] valid, input logic [1:0] dir,
                           input logic [2*W-1:0] tgt, input bit hold);
        int g, n, cyc, ens, bad;
        bit seen;
        logic d;
        logic [W-1:0] t;
        g = (valid == 2'b11) ? 1 - last_grant : (valid[1] ? 1 : 0);
        last_grant = g;
        d = dir[g];
        t = tgt[g*W +: W];
        n = steps(d, t);
        rif.req_valid  = valid;
        rif.req_dir    = dir;
        rif.req_target = tgt;
        #1;
        check("grant_ready", 32'(rif.req_ready), (g == 1) ? 32'd2 : 32'd1);
        cyc = 0; ens = 0; bad = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (!hold) rif.req_valid = 2'b00;
            if (rif.req_ready !== 2'b00 || busy !== 1'b1) bad++;
            if (cyc == 1) begin
                if (cnt_reset !== 1'b1 || cnt_up_down !== d || cnt_enable !== 1'b0) bad++;
            end else if (cnt_reset !== 1'b0) begin
                bad++;
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                if (cnt_up_down !== 1'b0 || cnt_enable !== 1'b0) bad++;
            end else if (cnt_up_down !== d) begin
                bad++;
            end
            if (cnt_enable === 1'b1) ens++;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_cycle", 32'(cyc), 32'(3 + n));
        check("enable_pulses", 32'(ens), 32'(n));
        check("done_id", 32'(done_id), 32'(g));
        check("final_count", 32'(cnt_count), 32'(t));
        check("job_cycle_rules", 32'(bad), 32'd0);
        @(negedge clock);
        check("after_done_idle", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int pulses;
        rif.req_valid  = 2'b11;
        rif.req_dir    = 2'b11;
        rif.req_target = '0;
        repeat (2) @(negedge clock);
        check("reset_outputs", {26'd0, rif.req_ready, cnt_reset, cnt_up_down, cnt_enable, busy, done, done_id}, 32'd0);
        rif.req_valid = 2'b00;
        reset_n = 1'b1;
        @(negedge clock);

        run_job(2'b01, 2'b01, {4'd0, 4'd5}, 1'b0);
        run_job(2'b10, 2'b00, {4'd12, 4'd0}, 1'b0);
        run_job(2'b01, 2'b01, {4'd0, 4'd0}, 1'b0);
        run_job(2'b10, 2'b10, {4'd15, 4'd3}, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_job(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 8'($urandom), 1'b0);
        end

        // reset in the middle of a RUN phase
        rif.req_valid  = 2'b01;
        rif.req_dir    = 2'b01;
        rif.req_target = {4'd0, 4'd9};
        repeat (3) @(negedge clock);
        rif.req_valid = 2'b11;
        reset_n = 1'b0;
        #1;
        check("midjob_reset_outputs", {26'd0, rif.req_ready, cnt_reset, cnt_up_down, cnt_enable, busy, done, done_id}, 32'd0);
        pulses = 0;
        repeat (3) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) pulses++;
        end
        check("midjob_reset_no_done", 32'(pulses), 32'd0);
        rif.req_valid = 2'b00;
        reset_n = 1'b1;
        last_grant = 1;
        @(negedge clock);
        run_job(2'b10, 2'b01, {4'd2, 4'd7}, 1'b0);
        last_grant = 1;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 4; i++) begin
            run_job(2'b11, 2'b10, {4'd3, 4'd2}, 1'b1);
        end
        rif.req_valid = 2'b00;
        @(negedge clock);

`ifdef COUNTER_SCHED_ABORT_EN
        rif.req_valid  = 2'b01;
        rif.req_dir    = 2'b01;
        rif.req_target = {4'd0, 4'd9};
        last_grant = 0;
        #1;
        check("abort_grant", 32'(rif.req_ready), 32'd1);
        @(negedge clock);
        rif.req_valid = 2'b00;
        @(negedge clock);
        @(negedge clock);
        abort = 1'b1;
        #1;
        check("abort_enable_low", 32'(cnt_enable), 32'd0);
        @(negedge clock);
        abort = 1'b0;
        check("abort_idle", {30'd0, busy, done}, 32'd0);
        check("abort_count", 32'(cnt_count), 32'd1);
        repeat (2) @(negedge clock);
        check("abort_no_done", {30'd0, busy, done}, 32'd0);
        run_job(2'b11, 2'b11, {4'd1, 4'd4}, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/counter_sched.md
COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 Parameter WIDTH, default 4, SHALL be the bit width of the counter datapath and of every target field.
REQ-002 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req_valid  input  2  SHALL carry one count request per requester (bit 0 = requester 0, bit 1 = requester 1).
REQ-005 req_dir  input  2  SHALL give each requester's direction: 1 = up, 0 = down.
REQ-006 req_target  input  2*WIDTH  SHALL give each requester's target; requester 0 occupies bits [WIDTH-1:0].
REQ-007 req_ready  output  2  SHALL signal acceptance of a request (one-hot or zero).
REQ-008 abort  input  1  SHALL request termination of the active job (only when COUNTER_SCHED_ABORT_EN is defined).
REQ-009 cnt_reset, cnt_up_down, cnt_enable  output  1 each  SHALL drive the shared counter's reset, direction and enable.
REQ-010 cnt_count  input  WIDTH  SHALL be the shared counter's current value.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.
REQ-012 done  output  1  SHALL pulse for one cycle when a job completes.
REQ-013 done_id  output  1  SHALL identify the requester whose job completed, and SHALL be valid while done=1.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, LOAD, RUN and DONE.
REQ-015 IDLE: if any req_valid bit is 1, the block SHALL grant one requester, assert its req_ready in the same cycle, latch its dir, target and id, and go to LOAD.
REQ-016 Arbitration SHALL be round-robin: with both requests valid, the grant SHALL go to the requester not granted last; with one valid, that requester SHALL be granted.
REQ-017 req_ready SHALL be 0 in LOAD, RUN and DONE; requests SHALL be ignored while busy.
REQ-018 LOAD: the block SHALL assert cnt_reset=1 and cnt_up_down=latched dir for exactly one cycle, then go to RUN; the counter then holds 0 (up) or all-ones (down).
REQ-019 RUN: cnt_up_down SHALL equal latched dir, and cnt_enable SHALL be the combinational value (cnt_count != latched target).
REQ-020 RUN: when cnt_count == target, the block SHALL go to DONE with cnt_enable=0, so the counter stops exactly on the target.
REQ-021 If target equals the start value (0 up / all-ones down), RUN SHALL last one cycle with zero enable pulses.
REQ-022 DONE: done=1 and done_id=latched id SHALL hold for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 Latency: request accepted in cycle 0 -> LOAD in cycle 1 -> DONE in cycle 3+N, where N = number of counter steps (up: target; down: 2^WIDTH-1-target).
REQ-024 Outside LOAD, cnt_reset SHALL be 0; outside RUN, cnt_enable SHALL be 0; in IDLE and DONE, cnt_up_down SHALL be 0.
REQ-025 A new request MAY be accepted in the IDLE cycle following DONE; back-to-back jobs SHALL have no extra gap.

Reset
REQ-026 While reset_n=0, the following SHALL be forced asynchronously: state=IDLE, round-robin pointer=requester 1 (so requester 0 wins the first tie), latched fields=0, and all outputs=0.
REQ-027 Reset asserted mid-job SHALL drop the job with no done pulse; the counter value after reset is left to the counter's own reset.

Configuration
REQ-028 Macro COUNTER_SCHED_ABORT_EN defined: abort=1 in LOAD or RUN SHALL move the FSM to IDLE on the next edge with cnt_enable=0 in that cycle, no done pulse, and no change to the round-robin pointer beyond the grant already made; abort SHALL be ignored in IDLE and DONE.
REQ-029 Macro undefined: the abort port SHALL NOT exist and jobs SHALL always run to DONE.

Verification
REQ-030 req_valid=01, dir=1, target=5 -> req_ready=01 in cycle 0; cnt_reset in cycle 1; exactly 5 enable cycles; done=1, done_id=0 in cycle 8; final count=5.
REQ-031 req_valid=10, dir=0, target=12 -> 3 enable pulses; count stops at 12; done_id=1 in cycle 6.
REQ-032 Both requesters held valid continuously after reset -> grants alternate 0,1,0,1 over four jobs, with no idle gap beyond one IDLE cycle.
REQ-033 dir=1, target=0 -> zero enable pulses; done in cycle 3.
REQ-034 reset_n pulsed low during RUN -> outputs go to 0 immediately; no done; next request is accepted normally.
REQ-035 (ABORT_EN) abort in the 2nd RUN cycle of an up job with target 9 -> cnt_enable=0 that cycle; IDLE next; no done; count=1.
